// File: rtl/serializador_paridad_tx_if.sv
// Word-source to serializer bus: valid/ready word handshake plus the registered
// serial-frame outputs seen by the parity cell array.
interface serializador_paridad_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             L;
  logic             frame;
  logic             par_slot;
  logic             busy;

  modport master (
    output data_in, load,
    input  ready, L, frame, par_slot, busy
  );

  modport slave (
    input  data_in, load,
    output ready, L, frame, par_slot, busy
  );
endinterface

// File: rtl/serializador_paridad_tx.sv
// Parallel-to-serial transmitter: sends WIDTH data bits LSB-first on L, then one
// parity bit, with back-to-back acceptance during the parity cycle.
module serializador_paridad_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter bit          PAR_ODD = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  serializador_paridad_tx_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             l_q, l_d;
  logic             frame_q, frame_d;
  logic             par_slot_q, par_slot_d;
  logic             busy_q, busy_d;
  logic             can_accept;
  logic             accept;
  logic             par_in;

  assign can_accept = (state_q == IDLE) || (state_q == PARITY);
  assign accept     = bus.load && can_accept;
  assign par_in     = PAR_ODD ? ~^bus.data_in : ^bus.data_in;

  // Outputs are registered, so next-state logic also computes what L/frame
  // must show in the cycle after the edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    l_d        = 1'b0;
    frame_d    = 1'b0;
    par_slot_d = 1'b0;
    busy_d     = 1'b0;

    unique case (state_q)
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        frame_d = 1'b1;
        busy_d  = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d    = PARITY;
          cnt_d      = '0;
          l_d        = par_q;
          par_slot_d = 1'b1;
        end else begin
          l_d = shreg_q[1];
        end
      end
      PARITY:  state_d = IDLE;
      default: state_d = state_q;
    endcase

    // A new word may enter from IDLE or straight out of the parity cycle.
    if (accept) begin
      state_d    = SHIFT;
      shreg_d    = bus.data_in;
      cnt_d      = '0;
      par_d      = par_in;
      l_d        = bus.data_in[0];
      frame_d    = 1'b1;
      par_slot_d = 1'b0;
      busy_d     = 1'b1;
    end
  end

  // NOTE: reset is asynchronous, so a mid-frame abort clears the line without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      l_q        <= 1'b0;
      frame_q    <= 1'b0;
      par_slot_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      l_q        <= l_d;
      frame_q    <= frame_d;
      par_slot_q <= par_slot_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ready    = can_accept;
  assign bus.L        = l_q;
  assign bus.frame    = frame_q;
  assign bus.par_slot = par_slot_q;
  assign bus.busy     = busy_q;
endmodule
